// File: rtl/mul_div_unit.sv
// mul_div_unit: multi-cycle HI/LO multiply/divide unit with mthi/mtlo writes.
// Results land in HI/LO a fixed number of busy cycles after the start cycle.
module mul_div_unit #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [2:0]  op,
   input  logic [31:0] A,
   input  logic [31:0] B,
   output logic        alubusy,
   output logic [31:0] hi,
   output logic [31:0] lo
);
   typedef enum logic {IDLE, BUSY} state_e;

   localparam logic [2:0] OP_MULT  = 3'd1;
   localparam logic [2:0] OP_MULTU = 3'd2;
   localparam logic [2:0] OP_DIV   = 3'd3;
   localparam logic [2:0] OP_DIVU  = 3'd4;
   localparam logic [2:0] OP_MTHI  = 3'd5;
   localparam logic [2:0] OP_MTLO  = 3'd6;

   state_e      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [2:0]  op_q, op_d;
   logic [31:0] a_q, a_d, b_q, b_d, hi_q, hi_d, lo_q, lo_d;

   logic        md_start, is_mul, is_sdiv;
   logic [63:0] prod_s, prod_u;
   logic [31:0] abs_a, abs_b, dvd, dvs, quo, rem, quo_s, rem_s;

   assign md_start = start && (op inside {[OP_MULT:OP_DIVU]});
   // start is ignored while reset is held, so it must not raise the stall either
   assign alubusy  = reset && (state_q == BUSY || md_start);
   assign hi       = hi_q;
   assign lo       = lo_q;

   assign is_mul  = op_q == OP_MULT || op_q == OP_MULTU;
   assign is_sdiv = op_q == OP_DIV;
   assign prod_s  = $signed({{32{a_q[31]}}, a_q}) * $signed({{32{b_q[31]}}, b_q});
   assign prod_u  = {32'd0, a_q} * {32'd0, b_q};

   // one unsigned divider on magnitudes; signs are restored afterwards so that
   // 0x80000000 / -1 wraps cleanly to 0x80000000 instead of overflowing
   assign abs_a = a_q[31] ? -a_q : a_q;
   assign abs_b = b_q[31] ? -b_q : b_q;
   assign dvd   = is_sdiv ? abs_a : a_q;
   assign dvs   = b_q == 32'd0 ? 32'd1 : (is_sdiv ? abs_b : b_q);
   assign quo   = dvd / dvs;
   assign rem   = dvd % dvs;
   assign quo_s = (a_q[31] ^ b_q[31]) ? -quo : quo;
   assign rem_s = a_q[31] ? -rem : rem;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      op_d    = op_q;
      a_d     = a_q;
      b_d     = b_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      if (state_q == IDLE) begin
         if (md_start) begin
            state_d = BUSY;
            op_d    = op;
            a_d     = A;
            b_d     = B;
            cnt_d   = (op == OP_MULT || op == OP_MULTU) ? 4'(MULT_CYCLES) : 4'(DIV_CYCLES);
         end else if (start && op == OP_MTHI) begin
            hi_d = A;
         end else if (start && op == OP_MTLO) begin
            lo_d = A;
         end
      end else begin
         cnt_d = cnt_q - 4'd1;
         if (cnt_q == 4'd1) begin
            state_d = IDLE;
            if (is_mul) begin
               {hi_d, lo_d} = op_q == OP_MULT ? prod_s : prod_u;
            end else if (b_q != 32'd0) begin
               hi_d = is_sdiv ? rem_s : rem;
               lo_d = is_sdiv ? quo_s : quo;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         op_q    <= '0;
         a_q     <= '0;
         b_q     <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         op_q    <= op_d;
         a_q     <= a_d;
         b_q     <= b_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
      end
   end
endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit: directed vectors; a negedge monitor checks HI/LO and busy
// length against a queue of expected results whenever alubusy falls.
module tb_mul_div_unit;
   logic        clk = 0, reset = 1, start = 0;
   logic [2:0]  op = 0;
   logic [31:0] A = 0, B = 0;
   logic        alubusy;
   logic [31:0] hi, lo;

   mul_div_unit dut (
      .clk(clk), .reset(reset), .start(start), .op(op), .A(A), .B(B),
      .alubusy(alubusy), .hi(hi), .lo(lo)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] hi;
      logic [31:0] lo;
      int          len;
   } exp_t;

   exp_t exp_q[$];
   int   n_cmp = 0, n_bad = 0;
   logic prev_busy = 0;
   int   run = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
      n_cmp++;
      if (act !== expv) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", nm, act, expv);
      end
   endtask

   always @(negedge clk) begin
      if (alubusy) begin
         run++;
      end else if (prev_busy) begin
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_done: busy run %0d with no expected result", run);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("busy_len", run, e.len);
            chk("hi", hi, e.hi);
            chk("lo", lo, e.lo);
         end
         run = 0;
      end
      prev_busy = alubusy;
   end

   task automatic md(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] eh, input logic [31:0] el, input int len);
      exp_q.push_back('{eh, el, len});
      @(posedge clk); #1 start = 1; op = o; A = a; B = b;
      @(posedge clk); #1 start = 0; op = 0; A = $urandom; B = $urandom;
      repeat (len) @(posedge clk);
   endtask

   task automatic mt(input logic [2:0] o, input logic [31:0] a);
      @(posedge clk); #1 start = 1; op = o; A = a;
      @(negedge clk); chk("mt_busy", alubusy, 0);
      @(posedge clk); #1 start = 0; op = 0;
      if (o == 3'd5) chk("mthi", hi, a);
      else chk("mtlo", lo, a);
   endtask

   initial begin
      #1 reset = 0;
      start = 1; op = 3'd1; A = 32'd9; B = 32'd9;
      #2 chk("rst_busy", alubusy, 0);
      repeat (2) @(posedge clk);
      #1 chk("rst_hi", hi, 0);
      chk("rst_lo", lo, 0);
      chk("rst_busy2", alubusy, 0);
      start = 0; op = 0; reset = 1;

      md(3'd1, 32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 32'hFFFFFFFA, 6);
      md(3'd2, 32'hFFFFFFFF, 32'd2,        32'h00000001, 32'hFFFFFFFE, 6);
      md(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 6);
      md(3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 6);
      md(3'd1, 32'h7FFFFFFF, 32'h80000000, 32'hC0000000, 32'h80000000, 6);
      md(3'd3, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 11);
      md(3'd4, 32'hFFFFFFF9, 32'd2,        32'h00000001, 32'h7FFFFFFC, 11);
      md(3'd3, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 11);
      md(3'd3, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 11);

      // back-to-back mthi / mtlo
      @(posedge clk); #1 start = 1; op = 3'd5; A = 32'h12345678;
      @(negedge clk); chk("mthi_busy", alubusy, 0);
      @(posedge clk); #1 chk("mthi_hi", hi, 32'h12345678);
      chk("mthi_lo", lo, 32'hFFFFFFFD);
      op = 3'd6; A = 32'h9ABCDEF0;
      @(negedge clk); chk("mtlo_busy", alubusy, 0);
      @(posedge clk); #1 chk("mtlo_lo", lo, 32'h9ABCDEF0);
      chk("mtlo_hi", hi, 32'h12345678);
      op = 3'd0;
      @(negedge clk); chk("none_busy", alubusy, 0);
      @(posedge clk); #1 op = 3'd7;
      @(negedge clk); chk("rsvd_busy", alubusy, 0);
      @(posedge clk); #1 start = 0; op = 0;
      chk("none_hi", hi, 32'h12345678);
      chk("none_lo", lo, 32'h9ABCDEF0);

      // divide by zero keeps HI/LO; a start inside BUSY is ignored
      mt(3'd5, 32'd5);
      mt(3'd6, 32'd7);
      exp_q.push_back('{32'd5, 32'd7, 11});
      @(posedge clk); #1 start = 1; op = 3'd4; A = 32'd1234; B = 32'd0;
      @(posedge clk); #1 start = 0; op = 0;
      repeat (2) @(posedge clk);
      #1 start = 1; op = 3'd1; A = 32'd3; B = 32'd3;
      @(posedge clk); #1 start = 0; op = 0;
      repeat (9) @(posedge clk);

      // reset at cnt=3 of a div
      exp_q.push_back('{32'd0, 32'd0, 8});
      @(posedge clk); #1 start = 1; op = 3'd3; A = 32'd100; B = 32'd7;
      @(posedge clk); #1 start = 0; op = 0;
      repeat (7) @(posedge clk);
      #1 reset = 0;
      #1 chk("abort_busy", alubusy, 0);
      chk("abort_hi", hi, 0);
      chk("abort_lo", lo, 0);
      repeat (2) @(posedge clk);
      #1 reset = 1;
      repeat (15) @(posedge clk);
      #1 chk("post_hi", hi, 0);
      chk("post_lo", lo, 0);
      chk("post_busy", alubusy, 0);

      // first edge after release accepts a start
      @(posedge clk); #1 reset = 0;
      @(posedge clk); #1 reset = 1; start = 1; op = 3'd5; A = 32'hCAFEF00D;
      @(posedge clk); #1 chk("first_edge_hi", hi, 32'hCAFEF00D);
      start = 0; op = 0;
      repeat (3) @(posedge clk);

      chk("queue_empty", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/mul_div_unit.md
MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001 SHALL have parameter MULT_CYCLES, default 5, busy length for mult/multu.
REQ-002 SHALL have parameter DIV_CYCLES, default 10, busy length for div/divu.
REQ-003 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port start, input, 1, launch request for the operation on op (from E-stage controller).
REQ-006 SHALL have port op, input, 3, encoding: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo; 7 reserved, treated as none.
REQ-007 SHALL have port A, input, 32, rs operand (already forwarded).
REQ-008 SHALL have port B, input, 32, rt operand (already forwarded).
REQ-009 SHALL have port alubusy, output, 1, busy flag consumed by the decode-stage stall logic.
REQ-010 SHALL have port hi, output, 32, current HI register.
REQ-011 SHALL have port lo, output, 32, current LO register.

Function
REQ-012 SHALL implement FSM with states IDLE and BUSY plus a 4-bit down-counter cnt.
REQ-013 In IDLE with start=1 and op in {1..4}: SHALL capture A, B and op at the edge, load cnt with MULT_CYCLES or DIV_CYCLES, and enter BUSY.
REQ-014 alubusy SHALL be 1 combinationally in the start cycle (start=1, op in {1..4}, state IDLE) and in every BUSY cycle, so decode stalls a following md-class instruction with no gap.
REQ-015 In BUSY: cnt SHALL decrement each edge; at the edge where cnt equals 1, the result SHALL be written to HI/LO and state SHALL return to IDLE.
REQ-016 Total latency SHALL be exactly MULT_CYCLES (or DIV_CYCLES) BUSY cycles after the start cycle; hi/lo show the new value on the first IDLE cycle.
REQ-017 start with any op while in BUSY SHALL be ignored (no capture, no HI/LO write); the stall logic keeps this from occurring legally.
REQ-018 mthi/mtlo with start=1 in IDLE SHALL write A to HI/LO at that edge; alubusy SHALL stay 0 and state SHALL stay IDLE.
REQ-019 mult SHALL compute the signed 64-bit product of A and B and multu the unsigned one; {HI,LO} = product.
REQ-020 div/divu SHALL set LO = quotient and HI = remainder; signed division truncates toward zero, and the remainder takes the sign of the dividend.
REQ-021 Signed 0x80000000 / 0xFFFFFFFF SHALL give LO=0x80000000, HI=0.
REQ-022 Divisor 0 SHALL still occupy DIV_CYCLES busy cycles; HI and LO SHALL keep their prior values.
REQ-023 Results SHALL depend only on the operands captured at start; A and B changing during BUSY SHALL have no effect.
REQ-024 hi and lo SHALL be driven directly from registers, with no combinational path from A or B.

Reset
REQ-025 reset=0 SHALL immediately, and independently of clk, force state IDLE, cnt=0, hi=0, lo=0, captured operands=0 and alubusy=0 (start is ignored while reset is low).
REQ-026 reset asserted mid-operation SHALL abort the operation, with no HI/LO write after release.
REQ-027 After reset rises, the first rising edge SHALL accept a start normally.

Verification
REQ-028 mult A=0xFFFFFFFE (-2), B=3, start 1 cycle -> alubusy high for 6 cycles (start + 5); then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
REQ-029 multu A=0xFFFFFFFF, B=2 -> hi=0x00000001, lo=0xFFFFFFFE after 5 busy cycles.
REQ-030 div A=0xFFFFFFF9 (-7), B=2 -> after 10 busy cycles lo=0xFFFFFFFD, hi=0xFFFFFFFF; divu with the same operands -> lo=0x7FFFFFFC, hi=1.
REQ-031 mthi A=0x12345678 then mtlo A=0x9ABCDEF0 on consecutive cycles -> alubusy stays 0; hi and lo update one edge after each start.
REQ-032 divu B=0 with prior hi=5, lo=7 -> busy 10 cycles; hi=5, lo=7 unchanged. A second start during BUSY -> ignored and counter not reloaded.
REQ-033 reset pulled low at cnt=3 of a div -> alubusy drops at once, hi=lo=0; no later write after release.
